depacketizer: RTL and testbench
===============================

DEPACKETIZER -- requirements
Module: depacketizer

Interface
REQ-001 SHALL have parameter SYNC_MIN, default 64: alternating preamble symbols required before phase-flip acceptance (2..223).
REQ-002 SHALL have port clk  in  1  symbol clock (1.024 MHz); one symbol per cycle when I_tvalid=1.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port I_tdata  in  2  hard-decision symbol; header uses bit0 only, QPSK payload uses [1:0].
REQ-005 SHALL have port I_tvalid  in  1  symbol valid; the block has no I_tready and never stalls input.
REQ-006 SHALL have port O_tdata  out  2  payload symbol; in BPSK bit1=0.
REQ-007 SHALL have ports O_tvalid, O_tlast, O_tuser  out  1 each: valid, last payload symbol, is_bpsk; no O_tready, because downstream is a FIFO.
REQ-008 SHALL have ports hdr_vld  out  1, pld_len  out  16, hdr_err  out  1: header-accepted pulse, decoded length in bits, header-error pulse.

Function
REQ-009 SHALL use frame layout in valid-symbol indices: 0..223 alternating; 224..255 inverted alternating (flip = two equal consecutive bits at 223/224); 256..263 mode; 264..279 length MSB first; 280..319 pad; 320.. payload.
REQ-010 SHALL use states HUNT, SYNC, FLIP, MODE, LEN, PAD, PLD; all counters advance only on I_tvalid=1 cycles.
REQ-011 HUNT: any valid symbol -> SYNC with alt_cnt=1.
REQ-012 SYNC: bit != previous -> alt_cnt++ (saturating at 255); bit == previous with alt_cnt>=SYNC_MIN -> FLIP with flip_cnt=1; bit == previous with alt_cnt<SYNC_MIN -> restart alt_cnt=1.
REQ-013 FLIP: 31 further symbols must alternate; any equal pair -> HUNT and pulse hdr_err; after the 31st -> MODE.
REQ-014 MODE: count matches of the 8 symbols against 1,0,1,0,1,0,1,0; >=5 -> BPSK, <=3 -> QPSK, ==4 -> HUNT plus hdr_err.
REQ-015 LEN: shift 16 bits MSB first into pld_len; then compute sym_len = BPSK ? len : len>>1 (16-bit, no rounding).
REQ-016 At LEN end, sym_len==0 -> HUNT plus hdr_err; otherwise -> PAD with a one-cycle hdr_vld, pld_len held stable until the next hdr_vld.
REQ-017 PAD: skip 40 symbols unchecked, then -> PLD.
REQ-018 PLD: each valid symbol -> registered output one cycle later, O_tvalid=1, O_tuser=is_bpsk, pld_cnt++; the symbol with pld_cnt==sym_len-1 carries O_tlast=1, then -> HUNT.
REQ-019 sym_len==1 SHALL yield a single output beat with O_tlast=1.
REQ-020 Outside PLD: O_tvalid=0, O_tlast=0, O_tdata=0, O_tuser=1.
REQ-021 I_tvalid=0 gaps inside any state SHALL hold state and counters; output latency stays exactly 1 cycle per valid symbol.
REQ-022 hdr_err and hdr_vld SHALL never assert in the same cycle.

Reset
REQ-023 On rst_n=0 at clk edge: state=HUNT; all counters 0; O_tdata=0, O_tvalid=0, O_tlast=0, O_tuser=1, hdr_vld=0, hdr_err=0, pld_len=0.
REQ-024 Reset mid-packet SHALL drop the packet with no O_tlast emitted; the first post-reset symbol is treated in HUNT.

Configuration
REQ-025 With DEPKT_STATS_EN defined: add outputs pkt_cnt (16) and err_cnt (16), incremented on O_tlast and hdr_err respectively, wrapping at 65535->0, reset to 0.
REQ-026 Without DEPKT_STATS_EN: those ports and counters SHALL be absent.

Structure
REQ-027 Package depkt_pkg SHALL hold constants ALT_LEN=224, FLIP_LEN=32, MODE_LEN=8, LEN_BITS=16, PAD_LEN=40, HDR_LEN=320, and the state enum.
REQ-028 Sub-module depkt_sync SHALL implement the HUNT/SYNC/FLIP alternation tracker and output a flip_found pulse; the top holds MODE..PLD.

Verification
REQ-029 BPSK frame, length=5, 320-symbol header -> hdr_vld once, pld_len=5, 5 beats O_tuser=1, O_tlast on beat 5.
REQ-030 QPSK frame, length=9 -> sym_len=4, 4 two-bit beats, O_tuser=0, O_tlast on beat 4.
REQ-031 Mode field with 4/8 matches -> hdr_err pulse, no O_tvalid, next clean frame decodes.
REQ-032 Flip after only 40 alternations (SYNC_MIN=64) -> no lock; a full 224-symbol preamble then locks.
REQ-033 Random I_tvalid=0 gaps (30%) through BPSK length=1 -> one beat with O_tvalid=1, O_tlast=1, identical payload.
REQ-034 rst_n=0 at payload beat 3 of 10 -> outputs reset next cycle, no O_tlast; under DEPKT_STATS_EN, pkt_cnt=0.

Source files
------------

// File: rtl/depkt_pkg.sv
// Shared constants and FSM state type for the depacketizer.
package depkt_pkg;

    localparam int ALT_LEN  = 224;
    localparam int FLIP_LEN = 32;
    localparam int MODE_LEN = 8;
    localparam int LEN_BITS = 16;
    localparam int PAD_LEN  = 40;
    localparam int HDR_LEN  = 320;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_SYNC,
        ST_FLIP,
        ST_MODE,
        ST_LEN,
        ST_PAD,
        ST_PLD
    } depkt_state_t;

    // Payload length in symbols: BPSK carries 1 bit per symbol, QPSK 2.
    function automatic logic [15:0] sym_len_f(input logic [15:0] len_bits, input logic is_bpsk);
        return is_bpsk ? len_bits : (len_bits >> 1);
    endfunction

endpackage

// File: rtl/depkt_if.sv
// Symbol stream in / payload stream out; neither direction has a ready.
interface depkt_if;
    logic [1:0] I_tdata;
    logic       I_tvalid;
    logic [1:0] O_tdata;
    logic       O_tvalid;
    logic       O_tlast;
    logic       O_tuser;

    modport master (output I_tdata, I_tvalid, input O_tdata, O_tvalid, O_tlast, O_tuser);
    modport slave  (input I_tdata, I_tvalid, output O_tdata, O_tvalid, O_tlast, O_tuser);
endinterface

// File: rtl/depkt_sync.sv
// Preamble alternation tracker: HUNT (idle) | SYNC (counting alternations) |
// FLIP (checking the 31 symbols after the phase flip).
module depkt_sync
    import depkt_pkg::*;
#(
    parameter int SYNC_MIN = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_valid,
    input  logic i_bit,
    output logic o_flip_found,
    output logic o_flip_err
);

    depkt_state_t r_state;
    logic         r_prev;
    logic [7:0]   r_alt_cnt;
    logic [4:0]   r_flip_cnt;
    logic         w_step;
    logic         w_alt;

    assign w_step = i_en & i_valid;
    assign w_alt  = i_bit ^ r_prev;

    // Combinational so the top can take the very next symbol as mode bit 0.
    assign o_flip_found = w_step && (r_state == ST_FLIP) && w_alt
                          && (r_flip_cnt == 5'(FLIP_LEN - 1));
    assign o_flip_err   = w_step && (r_state == ST_FLIP) && !w_alt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_HUNT;
            r_prev     <= 1'b0;
            r_alt_cnt  <= '0;
            r_flip_cnt <= '0;
        end else if (w_step) begin
            r_prev <= i_bit;
            case (r_state)
                ST_HUNT: begin
                    r_state   <= ST_SYNC;
                    r_alt_cnt <= 8'd1;
                end
                ST_SYNC: begin
                    if (w_alt) begin
                        if (r_alt_cnt != 8'hFF) r_alt_cnt <= r_alt_cnt + 8'd1;
                    end else if (r_alt_cnt >= 8'(SYNC_MIN)) begin
                        r_state    <= ST_FLIP;
                        r_flip_cnt <= 5'd1;
                        r_alt_cnt  <= '0;
                    end else begin
                        r_alt_cnt <= 8'd1;
                    end
                end
                ST_FLIP: begin
                    if (!w_alt || (r_flip_cnt == 5'(FLIP_LEN - 1))) begin
                        r_state    <= ST_HUNT;
                        r_flip_cnt <= '0;
                        r_alt_cnt  <= '0;
                    end else begin
                        r_flip_cnt <= r_flip_cnt + 5'd1;
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

endmodule

// File: rtl/depacketizer.sv
// Frame depacketizer: header decode (MODE/LEN/PAD) and payload streaming.
// Optional stats counters enabled by DEPKT_STATS_EN.
module depacketizer
    import depkt_pkg::*;
#(
    parameter int SYNC_MIN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    depkt_if.slave      s_if,
    output logic        hdr_vld,
    output logic [15:0] pld_len,
    output logic        hdr_err
`ifdef DEPKT_STATS_EN
    ,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
`endif
);

    // state | meaning
    // HUNT  | preamble search, owned by depkt_sync
    // MODE  | 8 mode symbols, majority vote against 10101010
    // LEN   | 16 length bits, MSB first
    // PAD   | 40 ignored symbols
    // PLD   | payload forwarding
    depkt_state_t r_state;
    logic [5:0]   r_cnt;
    logic [3:0]   r_match;
    logic         r_bpsk;
    logic [15:0]  r_len_sh;
    logic [15:0]  r_sym_len;
    logic [15:0]  r_pld_cnt;
    logic [15:0]  r_pld_len;
    logic         r_hdr_vld;
    logic         r_hdr_err;
    logic [1:0]   r_o_tdata;
    logic         r_o_tvalid;
    logic         r_o_tlast;
    logic         r_o_tuser;

    logic         w_vld;
    logic         w_bit;
    logic         w_flip_found;
    logic         w_flip_err;
    logic [3:0]   w_match_tot;
    logic [15:0]  w_len_nxt;
    logic [15:0]  w_sym_len;
    logic         w_pld_last;

    assign w_vld = s_if.I_tvalid;
    assign w_bit = s_if.I_tdata[0];

    depkt_sync #(.SYNC_MIN(SYNC_MIN)) u_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (r_state == ST_HUNT),
        .i_valid      (w_vld),
        .i_bit        (w_bit),
        .o_flip_found (w_flip_found),
        .o_flip_err   (w_flip_err)
    );

    // r_cnt counts down from MODE_LEN-1, so the expected mode bit is its LSB.
    assign w_match_tot = r_match + {3'b000, (w_bit == r_cnt[0])};
    assign w_len_nxt   = {r_len_sh[14:0], w_bit};
    assign w_sym_len   = sym_len_f(w_len_nxt, r_bpsk);
    assign w_pld_last  = (r_pld_cnt == r_sym_len - 16'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_HUNT;
            r_cnt      <= '0;
            r_match    <= '0;
            r_bpsk     <= 1'b1;
            r_len_sh   <= '0;
            r_sym_len  <= '0;
            r_pld_cnt  <= '0;
            r_pld_len  <= '0;
            r_hdr_vld  <= 1'b0;
            r_hdr_err  <= 1'b0;
            r_o_tdata  <= '0;
            r_o_tvalid <= 1'b0;
            r_o_tlast  <= 1'b0;
            r_o_tuser  <= 1'b1;
        end else begin
            r_hdr_vld  <= 1'b0;
            r_hdr_err  <= 1'b0;
            r_o_tdata  <= '0;
            r_o_tvalid <= 1'b0;
            r_o_tlast  <= 1'b0;
            r_o_tuser  <= 1'b1;
            case (r_state)
                ST_HUNT: begin
                    if (w_flip_err) r_hdr_err <= 1'b1;
                    if (w_flip_found) begin
                        r_state <= ST_MODE;
                        r_cnt   <= 6'(MODE_LEN - 1);
                        r_match <= '0;
                    end
                end
                ST_MODE: if (w_vld) begin
                    r_match <= w_match_tot;
                    if (r_cnt == 6'd0) begin
                        if (w_match_tot >= 4'd5) begin
                            r_bpsk  <= 1'b1;
                            r_state <= ST_LEN;
                            r_cnt   <= 6'(LEN_BITS - 1);
                        end else if (w_match_tot <= 4'd3) begin
                            r_bpsk  <= 1'b0;
                            r_state <= ST_LEN;
                            r_cnt   <= 6'(LEN_BITS - 1);
                        end else begin
                            r_state   <= ST_HUNT;
                            r_hdr_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                ST_LEN: if (w_vld) begin
                    r_len_sh <= w_len_nxt;
                    if (r_cnt != 6'd0) begin
                        r_cnt <= r_cnt - 6'd1;
                    end else if (w_sym_len == 16'd0) begin
                        r_state   <= ST_HUNT;
                        r_hdr_err <= 1'b1;
                    end else begin
                        r_state   <= ST_PAD;
                        r_cnt     <= 6'(PAD_LEN - 1);
                        r_hdr_vld <= 1'b1;
                        r_pld_len <= w_len_nxt;
                        r_sym_len <= w_sym_len;
                    end
                end
                ST_PAD: if (w_vld) begin
                    if (r_cnt == 6'd0) begin
                        r_state   <= ST_PLD;
                        r_pld_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                ST_PLD: begin
                    r_o_tuser <= r_bpsk;
                    if (w_vld) begin
                        r_o_tvalid <= 1'b1;
                        r_o_tdata  <= r_bpsk ? {1'b0, w_bit} : s_if.I_tdata;
                        r_o_tlast  <= w_pld_last;
                        if (w_pld_last) begin
                            r_state   <= ST_HUNT;
                            r_pld_cnt <= '0;
                        end else begin
                            r_pld_cnt <= r_pld_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    assign s_if.O_tdata  = r_o_tdata;
    assign s_if.O_tvalid = r_o_tvalid;
    assign s_if.O_tlast  = r_o_tlast;
    assign s_if.O_tuser  = r_o_tuser;
    assign hdr_vld       = r_hdr_vld;
    assign hdr_err       = r_hdr_err;
    assign pld_len       = r_pld_len;

`ifdef DEPKT_STATS_EN
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (r_o_tlast) r_pkt_cnt <= r_pkt_cnt + 16'd1;
            if (r_hdr_err) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign pkt_cnt = r_pkt_cnt;
    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_depacketizer.sv
// Directed bench for depacketizer: clean BPSK/QPSK frames, header errors,
// short-preamble rejection, input gaps and mid-payload reset.
module tb_depacketizer;

    logic clk;
    logic rst_n;
    logic hdr_vld;
    logic hdr_err;
    logic [15:0] pld_len;
`ifdef DEPKT_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;
`endif

    depkt_if u_if ();

    depacketizer #(.SYNC_MIN(64)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_if    (u_if),
        .hdr_vld (hdr_vld),
        .pld_len (pld_len),
        .hdr_err (hdr_err)
`ifdef DEPKT_STATS_EN
        ,
        .pkt_cnt (pkt_cnt),
        .err_cnt (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miscmp = 0;
    int cyc = 0;
    int n_vld = 0;
    int n_err = 0;
    int n_both = 0;
    int n_idle_bad = 0;
    logic [1:0] cap_d[$];
    logic       cap_l[$];
    logic       cap_u[$];
    int         cap_c[$];
    int         pld_cyc[$];
    logic [1:0] pl_q[$];
    logic [1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.O_tvalid) begin
            cap_d.push_back(u_if.O_tdata);
            cap_l.push_back(u_if.O_tlast);
            cap_u.push_back(u_if.O_tuser);
            cap_c.push_back(cyc);
        end else if (u_if.O_tlast || u_if.O_tdata != 2'b00) begin
            n_idle_bad++;
        end
        if (hdr_vld) n_vld++;
        if (hdr_err) n_err++;
        if (hdr_vld && hdr_err) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cap_d.delete(); cap_l.delete(); cap_u.delete(); cap_c.delete();
        pld_cyc.delete(); pl_q.delete(); exp_q.delete();
        n_vld = 0;
        n_err = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            u_if.I_tvalid = 1'b0;
            u_if.I_tdata  = 2'b00;
        end
    endtask

    task automatic put(input logic [1:0] d, input int gap, input bit is_pld);
        @(negedge clk);
        while (gap != 0 && $urandom_range(99, 0) < gap) begin
            u_if.I_tvalid = 1'b0;
            u_if.I_tdata  = 2'($urandom_range(3, 0));
            @(negedge clk);
        end
        u_if.I_tdata  = d;
        u_if.I_tvalid = 1'b1;
        if (is_pld) pld_cyc.push_back(cyc);
    endtask

    // Header bits go on bit0; bit1 is randomised since the header ignores it.
    task automatic hbit(input logic b, input int gap);
        put({1'($urandom_range(1, 0)), b}, gap, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] mode, input logic [15:0] len,
                              input int n_send, input int gap);
        for (int i = 0; i < 224; i++) hbit(1'((i % 2) == 1), gap);
        for (int i = 224; i < 256; i++) hbit(1'((i % 2) == 0), gap);
        for (int k = 7; k >= 0; k--) hbit(mode[k], gap);
        for (int k = 15; k >= 0; k--) hbit(len[k], gap);
        for (int i = 0; i < 40; i++) put(2'($urandom_range(3, 0)), gap, 1'b0);
        for (int i = 0; i < n_send; i++) put(pl_q[i], gap, 1'b1);
        idle(1);
    endtask

    task automatic check_frame(input string tag, input int e_vld, input int e_err,
                               input logic [15:0] e_len, input logic e_user, input bit last_on);
        chk({tag, ".hdr_vld"}, n_vld, e_vld);
        chk({tag, ".hdr_err"}, n_err, e_err);
        chk({tag, ".pld_len"}, {16'd0, pld_len}, {16'd0, e_len});
        chk({tag, ".beats"}, cap_d.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_d.size(); i++) begin
            chk($sformatf("%s.data[%0d]", tag, i), {30'd0, cap_d[i]}, {30'd0, exp_q[i]});
            chk($sformatf("%s.last[%0d]", tag, i), {31'd0, cap_l[i]},
                {31'd0, last_on && (i == exp_q.size() - 1)});
            chk($sformatf("%s.user[%0d]", tag, i), {31'd0, cap_u[i]}, {31'd0, e_user});
            if (i < pld_cyc.size())
                chk($sformatf("%s.lat[%0d]", tag, i), cap_c[i] - pld_cyc[i], 1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        u_if.I_tvalid = 1'b0;
        u_if.I_tdata  = 2'b00;
        idle(3);
        chk("rst.O_tvalid", {31'd0, u_if.O_tvalid}, 0);
        chk("rst.O_tlast", {31'd0, u_if.O_tlast}, 0);
        chk("rst.O_tdata", {30'd0, u_if.O_tdata}, 0);
        chk("rst.O_tuser", {31'd0, u_if.O_tuser}, 1);
        chk("rst.hdr_vld", {31'd0, hdr_vld}, 0);
        chk("rst.hdr_err", {31'd0, hdr_err}, 0);
        chk("rst.pld_len", {16'd0, pld_len}, 0);
        rst_n = 1'b1;
        idle(2);

        // BPSK, length 5; bit1 of the input must be dropped
        clr();
        pl_q  = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
        exp_q = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        send_frame(8'hAA, 16'd5, 5, 0);
        idle(4);
        check_frame("bpsk5", 1, 0, 16'd5, 1'b1, 1'b1);

        // mode 11110000 has exactly 4 matches
        clr();
        send_frame(8'hF0, 16'd5, 0, 0);
        idle(4);
        check_frame("mode4", 0, 1, 16'd5, 1'b1, 1'b1);

        // QPSK via 3 matches (01011011), length 9 -> 4 symbols
        clr();
        pl_q  = '{2'b11, 2'b10, 2'b01, 2'b00};
        exp_q = '{2'b11, 2'b10, 2'b01, 2'b00};
        send_frame(8'h5B, 16'd9, 4, 0);
        idle(4);
        check_frame("qpsk9", 1, 0, 16'd9, 1'b0, 1'b1);

        // QPSK length 1 -> zero symbols
        clr();
        send_frame(8'h55, 16'd1, 0, 0);
        idle(4);
        check_frame("qpsk_len1", 0, 1, 16'd9, 1'b0, 1'b1);

        // BPSK length 0
        clr();
        send_frame(8'hAA, 16'd0, 0, 0);
        idle(4);
        check_frame("bpsk_len0", 0, 1, 16'd9, 1'b1, 1'b1);

        // flip after only 40 alternations must not lock
        clr();
        for (int i = 0; i < 40; i++) hbit(1'((i % 2) == 1), 0);
        for (int i = 40; i < 72; i++) hbit(1'((i % 2) == 0), 0);
        idle(4);
        chk("short.hdr_vld", n_vld, 0);
        chk("short.hdr_err", n_err, 0);
        pl_q  = '{2'b01, 2'b00, 2'b01};
        exp_q = '{2'b01, 2'b00, 2'b01};
        send_frame(8'hAA, 16'd3, 3, 0);
        idle(4);
        check_frame("short_then_full", 1, 0, 16'd3, 1'b1, 1'b1);

        // 30% input gaps, BPSK via 5 matches (10101101), length 1
        clr();
        pl_q  = '{2'b01};
        exp_q = '{2'b01};
        send_frame(8'hAD, 16'd1, 1, 30);
        idle(4);
        check_frame("gap_len1", 1, 0, 16'd1, 1'b1, 1'b1);

`ifdef DEPKT_STATS_EN
        chk("stats.pkt_cnt", {16'd0, pkt_cnt}, 4);
        chk("stats.err_cnt", {16'd0, err_cnt}, 3);
`endif

        // reset during payload beat 3 of 10
        clr();
        pl_q  = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
        exp_q = '{2'b01, 2'b00, 2'b01};
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 1; j++) begin end
        end
        begin
            for (int i = 0; i < 224; i++) hbit(1'((i % 2) == 1), 0);
            for (int i = 224; i < 256; i++) hbit(1'((i % 2) == 0), 0);
            for (int k = 7; k >= 0; k--) hbit(1'((k % 2) == 1), 0);
            for (int k = 15; k >= 0; k--) hbit(1'(k == 1 || k == 3), 0);
            for (int i = 0; i < 40; i++) put(2'b00, 0, 1'b0);
            for (int i = 0; i < 3; i++) put(pl_q[i], 0, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        u_if.I_tdata  = pl_q[3];
        u_if.I_tvalid = 1'b1;
        @(negedge clk);
        u_if.I_tvalid = 1'b0;
        chk("midrst.O_tvalid", {31'd0, u_if.O_tvalid}, 0);
        chk("midrst.O_tlast", {31'd0, u_if.O_tlast}, 0);
        chk("midrst.O_tdata", {30'd0, u_if.O_tdata}, 0);
        chk("midrst.O_tuser", {31'd0, u_if.O_tuser}, 1);
`ifdef DEPKT_STATS_EN
        chk("midrst.pkt_cnt", {16'd0, pkt_cnt}, 0);
        chk("midrst.err_cnt", {16'd0, err_cnt}, 0);
`endif
        idle(2);
        rst_n = 1'b1;
        idle(4);
        check_frame("midrst", 1, 0, 16'd0, 1'b1, 1'b0);

        // clean frame after reset
        clr();
        pl_q  = '{2'b10, 2'b01};
        exp_q = '{2'b00, 2'b01};
        send_frame(8'hAA, 16'd2, 2, 0);
        idle(4);
        check_frame("post_rst", 1, 0, 16'd2, 1'b1, 1'b1);

        chk("hdr_vld_err_overlap", n_both, 0);
        chk("idle_outputs_nonzero", n_idle_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
